// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: N-channel arbiter between CPU-side SRAM-like request ports and
// one shared SRAM-like bus with an addr_ok/data_ok handshake. Only one transaction
// is in flight at a time.
//
// Build option: define ARB_TIMEOUT_EN to add a data-phase watchdog. When it fires,
// the transaction completes with ch_err=1 and a DEADBEEF read value. Without the
// macro, the DATA phase waits indefinitely and ch_err is tied low.
module mem_bus_arbiter #(
    parameter int N_CH     = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH-1:0]          ch_wr,
    input  logic [N_CH*DATA_W/8-1:0] ch_wstrb,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*DATA_W-1:0]   ch_wdata,
    output logic [N_CH-1:0]          ch_addr_ok,
    output logic [N_CH-1:0]          ch_data_ok,
    output logic                     ch_err,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     bus_req,
    output logic                     bus_wr,
    output logic [DATA_W/8-1:0]      bus_wstrb,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_wdata,
    input  logic                     bus_addr_ok,
    input  logic                     bus_data_ok,
    input  logic [DATA_W-1:0]        bus_rdata
);

    localparam int SW = DATA_W / 8;
    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF);

    if ((DATA_W % 8) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("mem_bus_arbiter: DATA_W must be a multiple of 8 and TIMEOUT in 1..65535");
    end

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t          state;
    state_t          state_nx;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   sel;
    logic            sel_valid;
    logic            wr_q;
    logic [SW-1:0]   wstrb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic            timeout_hit;
    logic            done;

    // Pick the winning channel: lowest index in fixed mode, first requester at/after ptr in RR mode
    always_comb begin
        int idx;
        idx       = 0;
        sel       = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (ARB_MODE == 1) begin
                idx = int'(ptr) + k;
                if (idx >= N_CH) idx = idx - N_CH;
            end else begin
                idx = k;
            end
            if (!sel_valid && ch_req[idx]) begin
                sel       = GW'(idx);
                sel_valid = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tcnt;

    // Data-phase cycle counter; held at zero through ADDR so it starts fresh on DATA entry
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcnt <= '0;
        end else if (state == ADDR) begin
            tcnt <= '0;
        end else if (state == DATA) begin
            tcnt <= tcnt + 16'd1;
        end
    end

    assign timeout_hit = (state == DATA) && (tcnt == TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    assign done = (state == DATA) && (bus_data_ok || timeout_hit);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus the one-cycle handshake responses back to the channels
    always_comb begin
        state_nx   = state;
        ch_addr_ok = '0;
        ch_data_ok = '0;
        ch_err     = 1'b0;
        ch_rdata   = '0;
        case (state)
            IDLE: begin
                if (sel_valid) state_nx = ADDR;
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    ch_addr_ok[grant] = 1'b1;
                    state_nx          = DATA;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    ch_data_ok[grant] = 1'b1;
                    ch_rdata          = bus_rdata;
                    state_nx          = IDLE;
                end else if (timeout_hit) begin
                    ch_data_ok[grant] = 1'b1;
                    ch_err            = 1'b1;
                    ch_rdata          = TIMEOUT_DATA;
                    state_nx          = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latch the granted channel's command on acceptance and advance the RR pointer on completion
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant   <= '0;
            ptr     <= '0;
            wr_q    <= 1'b0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (state == IDLE && sel_valid) begin
                grant   <= sel;
                wr_q    <= ch_wr[sel];
                wstrb_q <= ch_wstrb[int'(sel)*SW +: SW];
                addr_q  <= ch_addr[int'(sel)*ADDR_W +: ADDR_W];
                wdata_q <= ch_wdata[int'(sel)*DATA_W +: DATA_W];
            end
            if (done && ARB_MODE == 1) begin
                ptr <= (grant == GW'(N_CH - 1)) ? '0 : grant + GW'(1);
            end
        end
    end

    assign bus_req   = (state == ADDR);
    assign bus_wr    = wr_q;
    assign bus_wstrb = wstrb_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter. A 2-channel fixed-priority
// instance covers reset, reads, writes, priority and (with ARB_TIMEOUT_EN) the
// watchdog; a 3-channel round-robin instance covers grant rotation.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    // fixed-priority, 2-channel instance
    logic [1:0]  ch_req, ch_wr, ch_addr_ok, ch_data_ok;
    logic [7:0]  ch_wstrb;
    logic [63:0] ch_addr, ch_wdata;
    logic        ch_err;
    logic [31:0] ch_rdata;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    // round-robin, 3-channel instance
    logic [2:0]  r_ch_req, r_ch_wr, r_ch_addr_ok, r_ch_data_ok;
    logic [11:0] r_ch_wstrb;
    logic [95:0] r_ch_addr, r_ch_wdata;
    logic        r_ch_err;
    logic [31:0] r_ch_rdata;
    logic        r_bus_req, r_bus_wr, r_bus_addr_ok, r_bus_data_ok;
    logic [3:0]  r_bus_wstrb;
    logic [31:0] r_bus_addr, r_bus_wdata, r_bus_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          ch;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];

    mem_bus_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_wstrb(ch_wstrb), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok),
        .ch_err(ch_err), .ch_rdata(ch_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    mem_bus_arbiter #(.N_CH(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(8)) dut_rr (
        .clk(clk), .resetn(resetn),
        .ch_req(r_ch_req), .ch_wr(r_ch_wr), .ch_wstrb(r_ch_wstrb), .ch_addr(r_ch_addr),
        .ch_wdata(r_ch_wdata), .ch_addr_ok(r_ch_addr_ok), .ch_data_ok(r_ch_data_ok),
        .ch_err(r_ch_err), .ch_rdata(r_ch_rdata),
        .bus_req(r_bus_req), .bus_wr(r_bus_wr), .bus_wstrb(r_bus_wstrb), .bus_addr(r_bus_addr),
        .bus_wdata(r_bus_wdata), .bus_addr_ok(r_bus_addr_ok), .bus_data_ok(r_bus_data_ok),
        .bus_rdata(r_bus_rdata)
    );

    // Hard stop if the run ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] oh(input int ch);
        oh = 64'(1) << ch;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic wr, input logic [3:0] wstrb,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        ch_req[ch]             = 1'b1;
        ch_wr[ch]              = wr;
        ch_wstrb[ch*4 +: 4]    = wstrb;
        ch_addr[ch*32 +: 32]   = addr;
        ch_wdata[ch*32 +: 32]  = wdata;
    endtask

    task automatic checkFields(input string tag, input logic wr, input logic [3:0] wstrb,
                               input logic [31:0] addr, input logic [31:0] wdata);
        checkOutput({tag, "_bus_req"},   64'(bus_req),   64'(1));
        checkOutput({tag, "_bus_wr"},    64'(bus_wr),    64'(wr));
        checkOutput({tag, "_bus_wstrb"}, 64'(bus_wstrb), 64'(wstrb));
        checkOutput({tag, "_bus_addr"},  64'(bus_addr),  64'(addr));
        checkOutput({tag, "_bus_wdata"}, 64'(bus_wdata), 64'(wdata));
    endtask

    // Pop the next expected completion and compare it with what the DUT shows now
    task automatic checkCompletion(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: observed completion 0x%0h expected no pending entry", tag, ch_data_ok);
        end else begin
            e = sbq.pop_front();
            checkOutput({tag, "_data_ok"}, 64'(ch_data_ok), oh(e.ch));
            checkOutput({tag, "_rdata"},   64'(ch_rdata),   64'(e.rdata));
            checkOutput({tag, "_err"},     64'(ch_err),     64'(e.err));
        end
    endtask

    // Act as the bus for one transaction; called in the IDLE cycle where the request is visible
    task automatic busTransaction(input string tag, input int ch, input int addr_wait, input int data_wait,
                                  input logic [31:0] rdata, input logic wr, input logic [3:0] wstrb,
                                  input logic [31:0] addr, input logic [31:0] wdata, input bit release_req);
        exp_t e;
        stepCycle();
        for (int w = 0; w < addr_wait; w++) begin
            #1;
            checkFields({tag, "_wait"}, wr, wstrb, addr, wdata);
            checkOutput({tag, "_early_addr_ok"}, 64'(ch_addr_ok), 64'(0));
            stepCycle();
        end
        bus_addr_ok = 1'b1;
        #1;
        checkFields(tag, wr, wstrb, addr, wdata);
        checkOutput({tag, "_addr_ok"}, 64'(ch_addr_ok), oh(ch));
        stepCycle();
        bus_addr_ok = 1'b0;
        if (release_req) ch_req[ch] = 1'b0;
        for (int w = 0; w < data_wait; w++) begin
            #1;
            checkOutput({tag, "_data_bus_req"},   64'(bus_req),    64'(0));
            checkOutput({tag, "_early_data_ok"},  64'(ch_data_ok), 64'(0));
            checkOutput({tag, "_idle_rdata"},     64'(ch_rdata),   64'(0));
            stepCycle();
        end
        e = '{ch, rdata, 1'b0};
        sbq.push_back(e);
        bus_data_ok = 1'b1;
        bus_rdata   = rdata;
        #1;
        checkCompletion(tag);
        stepCycle();
        bus_data_ok = 1'b0;
        bus_rdata   = $urandom;
    endtask

    // Directed sequence
    initial begin
        resetn        = 1'b0;
        ch_req        = '0;  ch_wr = '0;  ch_wstrb = '0;  ch_addr = '0;  ch_wdata = '0;
        bus_addr_ok   = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        r_ch_req      = '0;  r_ch_wr = '0; r_ch_wstrb = '0; r_ch_addr = '0; r_ch_wdata = '0;
        r_bus_addr_ok = 1'b0; r_bus_data_ok = 1'b0; r_bus_rdata = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_bus_req",    64'(bus_req),    64'(0));
        checkOutput("reset_addr_ok",    64'(ch_addr_ok), 64'(0));
        checkOutput("reset_data_ok",    64'(ch_data_ok), 64'(0));
        checkOutput("reset_err",        64'(ch_err),     64'(0));
        checkOutput("reset_rdata",      64'(ch_rdata),   64'(0));
        checkOutput("reset_bus_addr",   64'(bus_addr),   64'(0));
        checkOutput("reset_bus_wr",     64'(bus_wr),     64'(0));
        resetn = 1'b1;
        stepCycle();

        // stray handshakes in IDLE must not produce responses
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h1234_5678;
        #1;
        checkOutput("stray_data_ok", 64'(ch_data_ok), 64'(0));
        checkOutput("stray_addr_ok", 64'(ch_addr_ok), 64'(0));
        checkOutput("stray_rdata",   64'(ch_rdata),   64'(0));
        stepCycle();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        #1;
        checkOutput("stray_stay_idle", 64'(bus_req), 64'(0));

        // single read on channel 1
        applyStimulus(1, 1'b0, 4'h0, 32'h1FC0_0000, 32'h0);
        busTransaction("read_ch1", 1, 1, 1, 32'h2408_0001, 1'b0, 4'h0, 32'h1FC0_0000, 32'h0, 1'b1);
        #1;
        checkOutput("post_read_rdata", 64'(ch_rdata), 64'(0));

        // fixed priority: channel 0 drains all its requests before channel 1
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
        applyStimulus(1, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
        for (int i = 0; i < 3; i++)
            busTransaction("prio_ch0", 0, 0, 0, 32'hA000_0000 + 32'(i), 1'b0, 4'hF, 32'h0000_1000, 32'h0, i == 2);
        for (int i = 0; i < 3; i++)
            busTransaction("prio_ch1", 1, 0, 0, 32'hB000_0000 + 32'(i), 1'b0, 4'hF, 32'h0000_2000, 32'h0, i == 2);

        // write with five address-phase wait cycles; write completion returns bus_rdata
        applyStimulus(0, 1'b1, 4'b0011, 32'h8000_0010, 32'h0000_ABCD);
        busTransaction("write_ch0", 0, 5, 2, 32'h0000_55AA, 1'b1, 4'b0011, 32'h8000_0010, 32'h0000_ABCD, 1'b1);

        // reset in the DATA phase drops the transaction even with bus_data_ok high
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_3000, 32'h0);
        stepCycle();
        bus_addr_ok = 1'b1;
        stepCycle();
        bus_addr_ok = 1'b0;
        ch_req[0]   = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hCAFE_F00D;
        resetn      = 1'b0;
        #1;
        checkOutput("midreset_data_ok", 64'(ch_data_ok), 64'(0));
        checkOutput("midreset_rdata",   64'(ch_rdata),   64'(0));
        checkOutput("midreset_bus_req", 64'(bus_req),    64'(0));
        checkOutput("midreset_bus_addr", 64'(bus_addr),  64'(0));
        stepCycle();
        bus_data_ok = 1'b0;
        resetn      = 1'b1;
        stepCycle();
        #1;
        checkOutput("midreset_idle", 64'(bus_req), 64'(0));

        // round robin with all three channels requesting continuously
        r_ch_req  = 3'b111;
        r_ch_addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        for (int i = 0; i < 6; i++) begin
            stepCycle();
            r_bus_addr_ok = 1'b1;
            #1;
            checkOutput("rr_addr_ok", 64'(r_ch_addr_ok), oh(i % 3));
            checkOutput("rr_bus_addr", 64'(r_bus_addr), 64'(32'h100 * ((i % 3) + 1)));
            stepCycle();
            r_bus_addr_ok = 1'b0;
            r_bus_data_ok = 1'b1;
            r_bus_rdata   = 32'h7700_0000 + 32'(i);
            #1;
            checkOutput("rr_data_ok", 64'(r_ch_data_ok), oh(i % 3));
            checkOutput("rr_rdata", 64'(r_ch_rdata), 64'(32'h7700_0000 + 32'(i)));
            stepCycle();
            r_bus_data_ok = 1'b0;
        end
        r_ch_req = '0;

`ifdef ARB_TIMEOUT_EN
        // no data_ok: watchdog completes on the eighth DATA cycle
        begin
            exp_t e;
            applyStimulus(0, 1'b0, 4'hF, 32'h0000_4000, 32'h0);
            stepCycle();
            bus_addr_ok = 1'b1;
            stepCycle();
            bus_addr_ok = 1'b0;
            ch_req[0]   = 1'b0;
            e = '{0, 32'hDEAD_BEEF, 1'b1};
            sbq.push_back(e);
            for (int k = 1; k < 8; k++) begin
                #1;
                checkOutput("tmo_early_data_ok", 64'(ch_data_ok), 64'(0));
                stepCycle();
            end
            #1;
            checkCompletion("timeout");
            stepCycle();
        end
        applyStimulus(1, 1'b0, 4'hF, 32'h0000_5000, 32'h0);
        busTransaction("after_tmo", 1, 0, 1, 32'h1111_2222, 1'b0, 4'hF, 32'h0000_5000, 32'h0, 1'b1);
        // data_ok arriving on the timeout cycle is a normal completion
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_6000, 32'h0);
        busTransaction("tmo_race", 0, 0, 7, 32'h3333_4444, 1'b0, 4'hF, 32'h0000_6000, 32'h0, 1'b1);
`endif

        checkOutput("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
